// File: rtl/commit_tx_eng_pkg.sv
// Shared types and constants for the VR COMMIT transmit engine.
//   vr_state      : snapshot source (view, commit number, own replica index)
//   vr_commit_hdr : COMMIT payload header, sent MSB-first at the top of the flit
//   replica_cfg   : one replica config table entry {ip, port}
//   udp_info      : UDP header handed to the TX path
package commit_tx_eng_pkg;

   localparam int NUM_REPLICAS = 3;
   localparam int REPLICA_W    = $clog2(NUM_REPLICAS);

   localparam logic [7:0] VR_COMMIT = 8'd4;

   typedef struct packed {
      logic [7:0]  msg_type;
      logic [63:0] view;
      logic [63:0] commit_num;
   } vr_commit_hdr;

   localparam int COMMIT_MSG_BYTES = $bits(vr_commit_hdr) / 8;

   typedef struct packed {
      logic [31:0] ip;
      logic [15:0] port;
   } replica_cfg;

   typedef struct packed {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] data_length;
   } udp_info;

   typedef struct packed {
      logic [63:0]          curr_view;
      logic [63:0]          commit_num;
      logic [REPLICA_W-1:0] my_replica_index;
   } vr_state;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNAP,
      ST_CFG_REQ,
      ST_CFG_RESP,
      ST_INFO,
      ST_DATA,
      ST_NEXT
   } tx_state_e;

endpackage

// File: rtl/commit_tx_eng_if.sv
// Handshake bundle around the COMMIT transmit engine.
//   manage request  : manager -> engine request to broadcast now
//   cfg read        : engine -> replica config table request/response
//   pkt info / data : engine -> UDP TX header and single payload flit
// master = engine side, slave = environment side.
interface commit_tx_eng_if
   import commit_tx_eng_pkg::*;
#(
   parameter int NOC_DATA_W = 512
) ();
   localparam int NOC_PADBYTES_W = $clog2(NOC_DATA_W / 8);

   logic                      manage_commit_tx_req_val;
   logic                      commit_tx_manage_req_rdy;

   logic                      commit_tx_cfg_rd_req_val;
   logic [REPLICA_W-1:0]      commit_tx_cfg_rd_req_addr;
   logic                      cfg_commit_tx_rd_req_rdy;
   logic                      cfg_commit_tx_rd_resp_val;
   replica_cfg                cfg_commit_tx_rd_resp_data;
   logic                      commit_tx_cfg_rd_resp_rdy;

   logic                      commit_tx_pkt_info_val;
   udp_info                   commit_tx_pkt_info;
   logic                      tx_commit_pkt_info_rdy;

   logic                      commit_tx_data_val;
   logic [NOC_DATA_W-1:0]     commit_tx_data;
   logic                      commit_tx_data_last;
   logic [NOC_PADBYTES_W-1:0] commit_tx_data_padbytes;
   logic                      tx_commit_data_rdy;

   modport master (
      input  manage_commit_tx_req_val,
      output commit_tx_manage_req_rdy,
      output commit_tx_cfg_rd_req_val, commit_tx_cfg_rd_req_addr,
      input  cfg_commit_tx_rd_req_rdy,
      input  cfg_commit_tx_rd_resp_val, cfg_commit_tx_rd_resp_data,
      output commit_tx_cfg_rd_resp_rdy,
      output commit_tx_pkt_info_val, commit_tx_pkt_info,
      input  tx_commit_pkt_info_rdy,
      output commit_tx_data_val, commit_tx_data, commit_tx_data_last,
      output commit_tx_data_padbytes,
      input  tx_commit_data_rdy
   );

   modport slave (
      output manage_commit_tx_req_val,
      input  commit_tx_manage_req_rdy,
      input  commit_tx_cfg_rd_req_val, commit_tx_cfg_rd_req_addr,
      output cfg_commit_tx_rd_req_rdy,
      output cfg_commit_tx_rd_resp_val, cfg_commit_tx_rd_resp_data,
      input  commit_tx_cfg_rd_resp_rdy,
      input  commit_tx_pkt_info_val, commit_tx_pkt_info,
      output tx_commit_pkt_info_rdy,
      input  commit_tx_data_val, commit_tx_data, commit_tx_data_last,
      input  commit_tx_data_padbytes,
      output tx_commit_data_rdy
   );

endinterface

// File: rtl/commit_tx_eng_datap.sv
// Datapath of the COMMIT transmit engine: holds the per-broadcast vr_state
// snapshot and the current replica config entry, and forms the UDP header and
// the single payload flit from them.
//   snap_en / snap_in       : capture view, commit number, own index
//   cfg_latch_en / cfg_in   : capture the destination replica entry
//   my_idx                  : own replica index from the snapshot
//   pkt_info/data/padbytes  : formed outputs, stable while the FSM holds
module commit_tx_eng_datap
   import commit_tx_eng_pkg::*;
#(
   parameter int NOC_DATA_W     = 512,
   parameter int NOC_PADBYTES_W = $clog2(NOC_DATA_W / 8)
) (
   input  logic                      clk,
   input  logic                      snap_en,
   input  vr_state                   snap_in,
   input  logic                      cfg_latch_en,
   input  replica_cfg                cfg_in,
   input  logic [31:0]               local_ip,
   input  logic [15:0]               local_port,
   output logic [REPLICA_W-1:0]      my_idx,
   output udp_info                   pkt_info,
   output logic [NOC_DATA_W-1:0]     data,
   output logic [NOC_PADBYTES_W-1:0] padbytes
);
   localparam int NOC_PADBYTES = NOC_DATA_W / 8;
   localparam int FILL_W       = NOC_DATA_W - $bits(vr_commit_hdr);

   logic [63:0]          view_p0;
   logic [63:0]          commit_p0;
   logic [REPLICA_W-1:0] my_idx_p0;
   replica_cfg           cfg_p1;
   vr_commit_hdr         hdr;

   // snapshot stage: captured once per broadcast, config once per replica
   always_ff @(posedge clk) begin
      if (snap_en) begin
         view_p0   <= snap_in.curr_view;
         commit_p0 <= snap_in.commit_num;
         my_idx_p0 <= snap_in.my_replica_index;
      end
      if (cfg_latch_en) begin
         cfg_p1 <= cfg_in;
      end
   end

   // formation stage
   always_comb begin
      hdr.msg_type   = VR_COMMIT;
      hdr.view       = view_p0;
      hdr.commit_num = commit_p0;

      pkt_info.src_ip      = local_ip;
      pkt_info.dst_ip      = cfg_p1.ip;
      pkt_info.src_port    = local_port;
      pkt_info.dst_port    = cfg_p1.port;
      pkt_info.data_length = 16'(COMMIT_MSG_BYTES);
   end

   assign data     = {hdr, {FILL_W{1'b0}}};
   assign padbytes = NOC_PADBYTES_W'(NOC_PADBYTES - COMMIT_MSG_BYTES);
   assign my_idx   = my_idx_p0;

endmodule

// File: rtl/commit_tx_eng.sv
// Primary-side VR COMMIT sender. On a manager request or heartbeat expiry it
// snapshots vr_state and sends one single-flit UDP COMMIT to every replica
// other than itself, reading each destination from the replica config table.
//   clk, rst                   : clock, synchronous active-high reset
//   commit_tx_en               : node is primary and NORMAL
//   vr_state_commit_tx_rd_data : live VR state, sampled at broadcast start
//   local_ip, local_port       : source address of outgoing packets
//   commit_tx_busy             : broadcast in progress
//   bus                        : request, cfg read, pkt info and data handshakes
module commit_tx_eng
   import commit_tx_eng_pkg::*;
#(
   parameter int NOC_DATA_W     = 512,
   parameter int HEARTBEAT_CYCS = 1000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            commit_tx_en,
   input  vr_state         vr_state_commit_tx_rd_data,
   input  logic [31:0]     local_ip,
   input  logic [15:0]     local_port,
   output logic            commit_tx_busy,
   commit_tx_eng_if.master bus
);
   localparam int                   HB_W     = (HEARTBEAT_CYCS > 1) ? $clog2(HEARTBEAT_CYCS) : 1;
   localparam logic [HB_W-1:0]      HB_LAST  = HB_W'(HEARTBEAT_CYCS - 1);
   localparam logic [REPLICA_W-1:0] LAST_IDX = REPLICA_W'(NUM_REPLICAS - 1);

   tx_state_e            state_q, state_d;
   logic [REPLICA_W-1:0] idx_q, idx_d;
   logic [REPLICA_W-1:0] snap_my_idx;
   logic [HB_W-1:0]      hb_cnt_q;
   logic                 pending_q;
   logic                 req_rdy_q;
   logic                 snap_en;
   logic                 cfg_latch_en;
   logic                 req_fire;
   logic                 hb_hit;
   logic                 bcast_start;

   assign req_fire    = bus.manage_commit_tx_req_val & req_rdy_q;
   assign hb_hit      = (state_q == ST_IDLE) & commit_tx_en & (hb_cnt_q == HB_LAST);
   assign bcast_start = (state_q == ST_IDLE) & pending_q & commit_tx_en;

   assign bus.commit_tx_manage_req_rdy = req_rdy_q;
   assign bus.commit_tx_cfg_rd_req_addr = idx_q;
   assign bus.commit_tx_data_last      = 1'b1;
   assign commit_tx_busy               = (state_q != ST_IDLE);

   // control stage: state, replica index, pending flag, heartbeat timer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         hb_cnt_q  <= '0;
         pending_q <= 1'b0;
         req_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         req_rdy_q <= 1'b1;

         if (!commit_tx_en || bcast_start) begin
            hb_cnt_q <= '0;
         end else if (state_q == ST_IDLE) begin
            hb_cnt_q <= hb_hit ? '0 : hb_cnt_q + 1'b1;
         end

         // A request landing in the start cycle is covered by the snapshot
         // taken in SNAP next cycle, so the start clear takes priority.
         if (!commit_tx_en || bcast_start) begin
            pending_q <= 1'b0;
         end else if (req_fire || hb_hit) begin
            pending_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d                       = state_q;
      idx_d                         = idx_q;
      snap_en                       = 1'b0;
      cfg_latch_en                  = 1'b0;
      bus.commit_tx_cfg_rd_req_val  = 1'b0;
      bus.commit_tx_cfg_rd_resp_rdy = 1'b0;
      bus.commit_tx_pkt_info_val    = 1'b0;
      bus.commit_tx_data_val        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bcast_start) state_d = ST_SNAP;
         end
         ST_SNAP: begin
            // snapshot is not registered yet, so skip test uses the live index
            snap_en = 1'b1;
            idx_d   = '0;
            state_d = (vr_state_commit_tx_rd_data.my_replica_index == '0) ? ST_NEXT : ST_CFG_REQ;
         end
         ST_CFG_REQ: begin
            bus.commit_tx_cfg_rd_req_val = 1'b1;
            if (bus.cfg_commit_tx_rd_req_rdy) state_d = ST_CFG_RESP;
         end
         ST_CFG_RESP: begin
            bus.commit_tx_cfg_rd_resp_rdy = 1'b1;
            if (bus.cfg_commit_tx_rd_resp_val) begin
               cfg_latch_en = 1'b1;
               state_d      = ST_INFO;
            end
         end
         ST_INFO: begin
            bus.commit_tx_pkt_info_val = 1'b1;
            if (bus.tx_commit_pkt_info_rdy) state_d = ST_DATA;
         end
         ST_DATA: begin
            bus.commit_tx_data_val = 1'b1;
            if (bus.tx_commit_data_rdy) state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = (idx_d == snap_my_idx) ? ST_NEXT : ST_CFG_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   commit_tx_eng_datap #(
      .NOC_DATA_W (NOC_DATA_W)
   ) u_datap (
      .clk          (clk),
      .snap_en      (snap_en),
      .snap_in      (vr_state_commit_tx_rd_data),
      .cfg_latch_en (cfg_latch_en),
      .cfg_in       (bus.cfg_commit_tx_rd_resp_data),
      .local_ip     (local_ip),
      .local_port   (local_port),
      .my_idx       (snap_my_idx),
      .pkt_info     (bus.commit_tx_pkt_info),
      .data         (bus.commit_tx_data),
      .padbytes     (bus.commit_tx_data_padbytes)
   );

endmodule

// File: tb/tb_commit_tx_eng.sv
module tb_commit_tx_eng;
   import commit_tx_eng_pkg::*;

   localparam int          NOC_DATA_W = 512;
   localparam int          HB         = 50;
   localparam logic [5:0]  EXP_PAD    = 6'd47;   // 64 - 17
   localparam logic [15:0] EXP_LEN    = 16'd17;  // 1 + 8 + 8 bytes

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   vr_state     vst = '0;
   logic [31:0] local_ip   = 32'hC0A8_0001;
   logic [15:0] local_port = 16'd7000;
   logic        busy;

   logic        req_val_t  = 1'b0;
   logic        req_rdy_t  = 1'b0;
   logic        resp_val_t = 1'b0;
   replica_cfg  resp_data_t = '0;
   logic        info_rdy_t = 1'b0;
   logic        data_rdy_t = 1'b0;
   bit          bp = 1'b0;
   bit          hold_data = 1'b0;

   int checks = 0;
   int errors = 0;

   commit_tx_eng_if #(.NOC_DATA_W(NOC_DATA_W)) bus ();

   assign bus.manage_commit_tx_req_val   = req_val_t;
   assign bus.cfg_commit_tx_rd_req_rdy   = req_rdy_t;
   assign bus.cfg_commit_tx_rd_resp_val  = resp_val_t;
   assign bus.cfg_commit_tx_rd_resp_data = resp_data_t;
   assign bus.tx_commit_pkt_info_rdy     = info_rdy_t;
   assign bus.tx_commit_data_rdy         = data_rdy_t;

   commit_tx_eng #(
      .NOC_DATA_W     (NOC_DATA_W),
      .HEARTBEAT_CYCS (HB)
   ) dut (
      .clk                        (clk),
      .rst                        (rst),
      .commit_tx_en               (en),
      .vr_state_commit_tx_rd_data (vst),
      .local_ip                   (local_ip),
      .local_port                 (local_port),
      .commit_tx_busy             (busy),
      .bus                        (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] cfg_ip(input int i);
      return 32'h0A00_0010 + 32'(i);
   endfunction

   function automatic logic [15:0] cfg_port(input int i);
      return 16'd6000 + 16'(i);
   endfunction

   function automatic logic [511:0] mk_data(input logic [63:0] v, input logic [63:0] c);
      logic [511:0] d;
      d = '0;
      d[511:504] = VR_COMMIT;
      d[503:440] = v;
      d[439:376] = c;
      return d;
   endfunction

   task automatic chk(input bit ok, input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   udp_info      exp_info_q[$];
   logic [511:0] exp_data_q[$];
   int           rise_q[$];
   int           fall_q[$];
   int           ncyc  = 0;
   int           n_info = 0;
   int           base  = 0;

   task automatic push_bcast(input int my, input logic [63:0] v, input logic [63:0] c);
      udp_info e;
      for (int i = 0; i < 3; i++) begin
         if (i != my) begin
            e.src_ip      = local_ip;
            e.dst_ip      = cfg_ip(i);
            e.src_port    = local_port;
            e.dst_port    = cfg_port(i);
            e.data_length = EXP_LEN;
            exp_info_q.push_back(e);
            exp_data_q.push_back(mk_data(v, c));
         end
      end
   endtask

   // handshake samples shared with the responder
   bit                   req_fire_s  = 1'b0;
   bit                   resp_fire_s = 1'b0;
   logic [REPLICA_W-1:0] addr_s = '0;

   // monitor: samples on the falling edge
   initial begin : monitor
      bit                   rst_prev = 1'b1;
      bit                   busy_prev = 1'b0;
      bit                   info_stall = 1'b0;
      bit                   data_stall = 1'b0;
      bit                   req_stall = 1'b0;
      udp_info              info_prev;
      logic [511:0]         data_prev;
      logic [REPLICA_W-1:0] addr_prev;
      udp_info              ei;
      logic [511:0]         ed;
      info_prev = '0;
      data_prev = '0;
      addr_prev = '0;
      forever begin
         @(negedge clk);
         ncyc++;
         if (!rst_prev) begin
            if (info_stall)
               chk(bus.commit_tx_pkt_info_val === 1'b1 && bus.commit_tx_pkt_info == info_prev,
                   "info_hold", bus.commit_tx_pkt_info, info_prev);
            if (data_stall)
               chk(bus.commit_tx_data_val === 1'b1 && bus.commit_tx_data == data_prev,
                   "data_hold", bus.commit_tx_data, data_prev);
            if (req_stall)
               chk(bus.commit_tx_cfg_rd_req_val === 1'b1 && bus.commit_tx_cfg_rd_req_addr == addr_prev,
                   "cfg_req_hold", bus.commit_tx_cfg_rd_req_addr, addr_prev);
         end

         req_fire_s  = bus.commit_tx_cfg_rd_req_val & bus.cfg_commit_tx_rd_req_rdy;
         resp_fire_s = bus.cfg_commit_tx_rd_resp_val & bus.commit_tx_cfg_rd_resp_rdy;
         addr_s      = bus.commit_tx_cfg_rd_req_addr;

         if (req_fire_s)
            chk(addr_s != vst.my_replica_index, "cfg_addr_self", addr_s, vst.my_replica_index);

         if (bus.commit_tx_pkt_info_val && bus.tx_commit_pkt_info_rdy) begin
            n_info++;
            if (exp_info_q.size() == 0) begin
               chk(1'b0, "info_extra", bus.commit_tx_pkt_info, 0);
            end else begin
               ei = exp_info_q.pop_front();
               chk(bus.commit_tx_pkt_info == ei, "pkt_info", bus.commit_tx_pkt_info, ei);
            end
         end

         if (bus.commit_tx_data_val && bus.tx_commit_data_rdy) begin
            if (exp_data_q.size() == 0) begin
               chk(1'b0, "data_extra", bus.commit_tx_data, 0);
            end else begin
               ed = exp_data_q.pop_front();
               chk(bus.commit_tx_data == ed, "data", bus.commit_tx_data, ed);
               chk(bus.commit_tx_data_last == 1'b1, "data_last", bus.commit_tx_data_last, 1);
               chk(bus.commit_tx_data_padbytes == EXP_PAD, "padbytes", bus.commit_tx_data_padbytes, EXP_PAD);
            end
         end

         if (busy === 1'b1 && !busy_prev) rise_q.push_back(ncyc);
         if (busy === 1'b0 && busy_prev) fall_q.push_back(ncyc);
         busy_prev = (busy === 1'b1);

         info_stall = bus.commit_tx_pkt_info_val & ~bus.tx_commit_pkt_info_rdy;
         data_stall = bus.commit_tx_data_val & ~bus.tx_commit_data_rdy;
         req_stall  = bus.commit_tx_cfg_rd_req_val & ~bus.cfg_commit_tx_rd_req_rdy;
         info_prev  = bus.commit_tx_pkt_info;
         data_prev  = bus.commit_tx_data;
         addr_prev  = bus.commit_tx_cfg_rd_req_addr;
         rst_prev   = rst;
      end
   end

   // config table and TX sink: ready/response driven just after the rising edge
   initial begin : responder
      bit                   pend = 1'b0;
      int                   dly = 0;
      logic [REPLICA_W-1:0] paddr = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            pend       = 1'b0;
            resp_val_t = 1'b0;
         end else begin
            if (resp_fire_s) resp_val_t = 1'b0;
            if (req_fire_s) begin
               pend  = 1'b1;
               paddr = addr_s;
               dly   = bp ? int'($urandom_range(0, 2)) : 0;
            end
            if (pend && !resp_val_t) begin
               if (dly == 0) begin
                  resp_val_t       = 1'b1;
                  resp_data_t.ip   = cfg_ip(int'(paddr));
                  resp_data_t.port = cfg_port(int'(paddr));
                  pend             = 1'b0;
               end else begin
                  dly--;
               end
            end
         end
         req_rdy_t  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         info_rdy_t = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         data_rdy_t = hold_data ? 1'b0 : (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      exp_info_q.delete();
      exp_data_q.delete();
      rise_q.delete();
      fall_q.delete();
      base = ncyc;
   endtask

   task automatic pulse_req();
      req_val_t = 1'b1;
      step();
      req_val_t = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string name);
      int n = 0;
      while ((busy || exp_info_q.size() != 0 || exp_data_q.size() != 0) && n < maxc) begin
         step();
         n++;
      end
      chk(n < maxc, name, n, maxc);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int ninfo0;

      // reset state
      step();
      step();
      chk(busy == 1'b0, "rst_busy", busy, 0);
      chk(bus.commit_tx_manage_req_rdy == 1'b0, "rst_req_rdy", bus.commit_tx_manage_req_rdy, 0);
      chk(bus.commit_tx_cfg_rd_req_val == 1'b0, "rst_cfg_val", bus.commit_tx_cfg_rd_req_val, 0);
      chk(bus.commit_tx_pkt_info_val == 1'b0, "rst_info_val", bus.commit_tx_pkt_info_val, 0);
      chk(bus.commit_tx_data_val == 1'b0, "rst_data_val", bus.commit_tx_data_val, 0);
      rst = 1'b0;
      step();
      chk(bus.commit_tx_manage_req_rdy == 1'b1, "req_rdy_after_rst", bus.commit_tx_manage_req_rdy, 1);

      // my_index 0: packets to replicas 1 and 2
      en = 1'b1;
      vst.curr_view = 64'd5;
      vst.commit_num = 64'd17;
      vst.my_replica_index = 2'd0;
      do_reset();
      step();
      push_bcast(0, 64'd5, 64'd17);
      pulse_req();
      wait_idle(100, "t1_idle");
      chk(rise_q.size() == 1, "t1_bcasts", rise_q.size(), 1);

      // my_index 1: packets to 0 then 2
      vst.my_replica_index = 2'd1;
      do_reset();
      step();
      push_bcast(1, 64'd5, 64'd17);
      pulse_req();
      wait_idle(100, "t2_idle");
      chk(rise_q.size() == 1, "t2_bcasts", rise_q.size(), 1);

      // heartbeat only: SNAP at cycle 51, 12 busy cycles, 51 idle cycles between
      vst.curr_view = 64'd7;
      vst.commit_num = 64'd9;
      vst.my_replica_index = 2'd0;
      do_reset();
      for (int i = 0; i < 3; i++) push_bcast(0, 64'd7, 64'd9);
      repeat (200) step();
      chk(rise_q.size() == 3, "hb_count", rise_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk(i < rise_q.size() && rise_q[i] == base + 52 + 63 * i, "hb_rise", (i < rise_q.size()) ? rise_q[i] - base : -1, 52 + 63 * i);
         chk(i < fall_q.size() && fall_q[i] == base + 64 + 63 * i, "hb_fall", (i < fall_q.size()) ? fall_q[i] - base : -1, 64 + 63 * i);
      end
      chk(exp_info_q.size() == 0 && exp_data_q.size() == 0, "hb_all_sent", exp_info_q.size(), 0);

      // requests during a broadcast with commit 17 -> 20: one follow-up
      vst.commit_num = 64'd17;
      vst.curr_view = 64'd5;
      do_reset();
      step();
      push_bcast(0, 64'd5, 64'd17);
      pulse_req();
      ninfo0 = n_info;
      n = 0;
      while (n_info == ninfo0 && n < 50) begin
         step();
         n++;
      end
      chk(n < 50, "t4_first_info", n, 50);
      pulse_req();
      vst.commit_num = 64'd20;
      pulse_req();
      pulse_req();
      push_bcast(0, 64'd5, 64'd20);
      wait_idle(200, "t4_idle");
      chk(rise_q.size() == 2, "t4_bcasts", rise_q.size(), 2);

      // random backpressure on cfg, info and data
      bp = 1'b1;
      do_reset();
      step();
      for (int k = 0; k < 4; k++) begin
         vst.curr_view = 64'(100 + k);
         vst.commit_num = 64'(200 + k);
         vst.my_replica_index = (k % 2 == 0) ? 2'd0 : 2'd2;
         push_bcast((k % 2 == 0) ? 0 : 2, 64'(100 + k), 64'(200 + k));
         pulse_req();
         wait_idle(400, "bp_idle");
      end
      chk(rise_q.size() == 4, "bp_bcasts", rise_q.size(), 4);
      bp = 1'b0;

      // disabled: requests accepted and dropped
      en = 1'b0;
      vst.my_replica_index = 2'd0;
      do_reset();
      step();
      ninfo0 = n_info;
      repeat (4) pulse_req();
      chk(bus.commit_tx_manage_req_rdy == 1'b1, "dis_req_rdy", bus.commit_tx_manage_req_rdy, 1);
      repeat (20) step();
      chk(rise_q.size() == 0, "dis_no_bcast", rise_q.size(), 0);
      chk(n_info == ninfo0, "dis_no_info", n_info - ninfo0, 0);
      en = 1'b1;
      repeat (20) step();
      chk(rise_q.size() == 0, "dis_pending_dropped", rise_q.size(), 0);

      // reset while stalled in DATA with a follow-up pending
      do_reset();
      step();
      hold_data = 1'b1;
      push_bcast(0, 64'd5, 64'd20);
      pulse_req();
      n = 0;
      while (!bus.commit_tx_data_val && n < 50) begin
         step();
         n++;
      end
      chk(n < 50, "t7_reach_data", n, 50);
      pulse_req();
      step();
      rst = 1'b1;
      step();
      chk(bus.commit_tx_data_val == 1'b0, "mid_rst_data_val", bus.commit_tx_data_val, 0);
      chk(bus.commit_tx_pkt_info_val == 1'b0, "mid_rst_info_val", bus.commit_tx_pkt_info_val, 0);
      chk(bus.commit_tx_cfg_rd_req_val == 1'b0, "mid_rst_cfg_val", bus.commit_tx_cfg_rd_req_val, 0);
      chk(busy == 1'b0, "mid_rst_busy", busy, 0);
      chk(bus.commit_tx_manage_req_rdy == 1'b0, "mid_rst_req_rdy", bus.commit_tx_manage_req_rdy, 0);
      rst = 1'b0;
      hold_data = 1'b0;
      exp_info_q.delete();
      exp_data_q.delete();
      rise_q.delete();
      repeat (20) step();
      chk(rise_q.size() == 0, "mid_rst_pending_cleared", rise_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
